// File: rtl/display_scheduler.sv
// Mode sequencer for the seven-segment display selector: arbitrates VIP and
// static-data requests, times each dwell and publishes remaining seconds as BCD.
module display_scheduler #(
  parameter int TICK_CYC = 100_000_000,
  parameter int VIP_SEC  = 10,
  parameter int DATA_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vip_req,
  input  logic       data_req,
  output logic [1:0] mode,
  output logic       vip_ack,
  output logic       data_ack,
  output logic [3:0] remain1,
  output logic [3:0] remain0
);

  localparam int PW = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_FLOW   = 2'b01;
  localparam logic [1:0] S_VIP    = 2'b10;
  localparam logic [1:0] S_STATIC = 2'b11;

  localparam logic [3:0]    VIP_T   = 4'(VIP_SEC / 10);
  localparam logic [3:0]    VIP_U   = 4'(VIP_SEC % 10);
  localparam logic [3:0]    DATA_T  = 4'(DATA_SEC / 10);
  localparam logic [3:0]    DATA_U  = 4'(DATA_SEC % 10);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    rem1_q, rem1_d;
  logic [3:0]    rem0_q, rem0_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          pend_q, pend_d;
  logic          vack_q, vack_d;
  logic          dack_q, dack_d;
  logic          tick_s;
  logic          expire_s;

  assign tick_s   = (pre_q == PRE_TOP);
  assign expire_s = tick_s && (rem1_q == 4'd0) && (rem0_q == 4'd1);

  // Next-state, dwell counter and acknowledge logic.
  always_comb begin
    state_d = state_q;
    rem1_d  = rem1_q;
    rem0_d  = rem0_q;
    pre_d   = pre_q;
    pend_d  = pend_q;
    vack_d  = 1'b0;
    dack_d  = 1'b0;

    // Free-running dwell countdown; request handling below overrides it on loads.
    if (state_q == S_VIP || state_q == S_STATIC) begin
      if (tick_s) begin
        pre_d = {PW{1'b0}};
        if (!expire_s) begin
          if (rem0_q == 4'd0) begin
            rem0_d = 4'd9;
            rem1_d = rem1_q - 4'd1;
          end else begin
            rem0_d = rem0_q - 4'd1;
          end
        end else begin
          rem0_d = rem0_q;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end

    if (!enable) begin
      state_d = S_OFF;
      pend_d  = 1'b0;
      rem1_d  = 4'd0;
      rem0_d  = 4'd0;
      pre_d   = {PW{1'b0}};
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_FLOW;
        end
        S_FLOW: begin
          if (vip_req) begin
            state_d = S_VIP;
            {rem1_d, rem0_d} = {VIP_T, VIP_U};
            pre_d   = {PW{1'b0}};
            vack_d  = 1'b1;
            pend_d  = data_req;
            dack_d  = data_req;
          end else if (data_req) begin
            state_d = S_STATIC;
            {rem1_d, rem0_d} = {DATA_T, DATA_U};
            pre_d   = {PW{1'b0}};
            dack_d  = 1'b1;
          end else begin
            state_d = S_FLOW;
          end
        end
        S_VIP: begin
          if (data_req) begin
            pend_d = 1'b1;
            dack_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
          if (vip_req) begin
            {rem1_d, rem0_d} = {VIP_T, VIP_U};
            pre_d  = {PW{1'b0}};
            vack_d = 1'b1;
          end else if (expire_s) begin
            // A data request arriving in the expiry cycle still counts as pending.
            if (pend_q || data_req) begin
              state_d = S_STATIC;
              {rem1_d, rem0_d} = {DATA_T, DATA_U};
              pre_d   = {PW{1'b0}};
              pend_d  = 1'b0;
            end else begin
              state_d = S_FLOW;
              {rem1_d, rem0_d} = 8'h00;
              pre_d   = {PW{1'b0}};
            end
          end else begin
            state_d = S_VIP;
          end
        end
        S_STATIC: begin
          if (vip_req) begin
            state_d = S_VIP;
            {rem1_d, rem0_d} = {VIP_T, VIP_U};
            pre_d   = {PW{1'b0}};
            vack_d  = 1'b1;
            pend_d  = data_req;
            dack_d  = data_req;
          end else if (data_req) begin
            {rem1_d, rem0_d} = {DATA_T, DATA_U};
            pre_d   = {PW{1'b0}};
            dack_d  = 1'b1;
          end else if (expire_s) begin
            state_d = S_FLOW;
            {rem1_d, rem0_d} = 8'h00;
            pre_d   = {PW{1'b0}};
          end else begin
            state_d = S_STATIC;
          end
        end
        default: begin
          state_d = S_OFF;
          pend_d  = 1'b0;
          {rem1_d, rem0_d} = 8'h00;
          pre_d   = {PW{1'b0}};
        end
      endcase
    end
  end

  // Registered mode decode of the next state.
  always_comb begin
    case (state_d)
      S_OFF:    mode_d = 2'b00;
      S_FLOW:   mode_d = 2'b01;
      S_VIP:    mode_d = 2'b10;
      S_STATIC: mode_d = 2'b11;
      default:  mode_d = 2'b00;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      mode_q  <= 2'b00;
      rem1_q  <= 4'd0;
      rem0_q  <= 4'd0;
      pre_q   <= {PW{1'b0}};
      pend_q  <= 1'b0;
      vack_q  <= 1'b0;
      dack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem1_q  <= rem1_d;
      rem0_q  <= rem0_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      vack_q  <= vack_d;
      dack_q  <= dack_d;
    end
  end

  assign mode     = mode_q;
  assign vip_ack  = vack_q;
  assign data_ack = dack_q;
  assign remain1  = rem1_q;
  assign remain0  = rem0_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: two instances (DATA_SEC 2 and 12) driven in lockstep
// and compared each cycle against a cycle-count based reference model.
module tb_display_scheduler;

  localparam int T  = 4;
  localparam int V  = 3;
  localparam int D0 = 2;
  localparam int D1 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, vip_req, data_req;
  logic [1:0] mode_s [2];
  logic       vack_s [2];
  logic       dack_s [2];
  logic [3:0] r1_s   [2];
  logic [3:0] r0_s   [2];

  display_scheduler #(.TICK_CYC(T), .VIP_SEC(V), .DATA_SEC(D0)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .vip_req(vip_req), .data_req(data_req),
    .mode(mode_s[0]), .vip_ack(vack_s[0]), .data_ack(dack_s[0]),
    .remain1(r1_s[0]), .remain0(r0_s[0]));

  display_scheduler #(.TICK_CYC(T), .VIP_SEC(V), .DATA_SEC(D1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .vip_req(vip_req), .data_req(data_req),
    .mode(mode_s[1]), .vip_ack(vack_s[1]), .data_ack(dack_s[1]),
    .remain1(r1_s[1]), .remain0(r0_s[1]));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode number, cycles left until expiry, pending flag, expected acks.
  int m_mode [2];
  int m_left [2];
  bit m_pend [2];
  bit m_va   [2];
  bit m_da   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int dsec(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_left[i] = 0; m_pend[i] = 1'b0; m_va[i] = 1'b0; m_da[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit en, input bit v, input bit d);
    m_va[i] = 1'b0;
    m_da[i] = 1'b0;
    if (!en) begin
      m_mode[i] = 0; m_pend[i] = 1'b0; m_left[i] = 0;
    end else if (m_mode[i] == 0) begin
      m_mode[i] = 1;
    end else if (m_mode[i] == 1) begin
      if (v) begin
        m_mode[i] = 2; m_left[i] = V * T; m_va[i] = 1'b1;
        if (d) begin m_pend[i] = 1'b1; m_da[i] = 1'b1; end
      end else if (d) begin
        m_mode[i] = 3; m_left[i] = dsec(i) * T; m_da[i] = 1'b1;
      end
    end else if (m_mode[i] == 2) begin
      if (d) begin m_pend[i] = 1'b1; m_da[i] = 1'b1; end
      if (v) begin
        m_left[i] = V * T; m_va[i] = 1'b1;
      end else if (m_left[i] == 1) begin
        if (m_pend[i]) begin
          m_mode[i] = 3; m_left[i] = dsec(i) * T; m_pend[i] = 1'b0;
        end else begin
          m_mode[i] = 1; m_left[i] = 0;
        end
      end else begin
        m_left[i]--;
      end
    end else begin
      if (v) begin
        m_mode[i] = 2; m_left[i] = V * T; m_va[i] = 1'b1;
        m_pend[i] = d; m_da[i] = d;
      end else if (d) begin
        m_left[i] = dsec(i) * T; m_da[i] = 1'b1;
      end else if (m_left[i] == 1) begin
        m_mode[i] = 1; m_left[i] = 0;
      end else begin
        m_left[i]--;
      end
    end
  endtask

  task automatic check_all();
    int sec;
    for (int i = 0; i < 2; i++) begin
      sec = (m_left[i] + T - 1) / T;
      chk($sformatf("mode%0d", i), mode_s[i], m_mode[i]);
      chk($sformatf("remain1_%0d", i), r1_s[i], sec / 10);
      chk($sformatf("remain0_%0d", i), r0_s[i], sec % 10);
      chk($sformatf("vip_ack%0d", i), vack_s[i], m_va[i]);
      chk($sformatf("data_ack%0d", i), dack_s[i], m_da[i]);
    end
  endtask

  task automatic cycle(input bit en, input bit v, input bit d);
    enable = en; vip_req = v; data_req = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, en, v, d);
    #1;
    check_all();
    vip_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; vip_req = 1'b0; data_req = 1'b0;
    model_reset();
    #12;
    check_all();
    enable = 1'b1;
    @(posedge clk); #1;
    check_all();
    @(negedge clk) rst = 1'b1;

    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0); idle(13);
    cycle(1'b1, 1'b1, 1'b1); idle(22);
    cycle(1'b1, 1'b0, 1'b1); idle(5);
    cycle(1'b1, 1'b1, 1'b0); idle(14);
    cycle(1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      idle(9);
      cycle(1'b1, 1'b1, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b1); idle(3);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    idle(3);
    cycle(1'b1, 1'b0, 1'b1); idle(52);

    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 13) == 0),
            ($urandom_range(0, 9) == 0));
    end

    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0); idle(2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk) rst = 1'b1;
    idle(3);
    cycle(1'b1, 1'b0, 1'b1); idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
